// File: rtl/control_unit_if.sv
// Control strobe bundle between the control sequencer (master) and the datapath (slave).
// stop and IR flow into the sequencer; every other signal is a datapath control input.
interface control_unit_if;
  logic        stop;
  logic [31:0] IR;
  logic        PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin;
  logic        read, write, IRin, Yin, IncPc;
  logic        Cout, BAout, Rin, Rout, GRA, GRB, GRC;
  logic [1:0]  mdr_read;
  logic [3:0]  control;
  logic        run;

  modport master (
    input  stop, IR,
    output PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin,
           read, write, IRin, Yin, IncPc,
           Cout, BAout, Rin, Rout, GRA, GRB, GRC,
           mdr_read, control, run
  );

  modport slave (
    output stop, IR,
    input  PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin,
           read, write, IRin, Yin, IncPc,
           Cout, BAout, Rin, Rout, GRA, GRB, GRC,
           mdr_read, control, run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer: IDLE, T0-T7, HALT.
// State is registered; strobes are decoded from state, and from IR during T3-T7.
module control_unit (
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master cu
);
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] opcode;
  logic       op_ld, op_st, op_ldi, op_alu, op_addi, op_halt;
  logic       op_mem, op_short, last_step;
  logic [3:0] alu_ctrl;
  logic       unused_ir;

  assign opcode    = cu.IR[31:27];
  assign unused_ir = ^cu.IR[26:0];

  assign op_ld    = (opcode == OP_LD);
  assign op_st    = (opcode == OP_ST);
  assign op_ldi   = (opcode == OP_LDI);
  assign op_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);
  assign op_addi  = (opcode == OP_ADDI);
  assign op_halt  = (opcode == OP_HALT);
  assign op_mem   = op_ld || op_st;
  assign op_short = op_ldi || op_alu || op_addi;

  // nop and unrecognised opcodes retire in T3
  assign last_step = ((state_q == S_T3) && !op_mem && !op_short && !op_halt) ||
                     ((state_q == S_T5) && op_short) ||
                     ((state_q == S_T7) && op_mem);

  always_comb begin
    alu_ctrl = 4'd2;
    case (opcode)
      OP_SUB:  alu_ctrl = 4'd3;
      OP_AND:  alu_ctrl = 4'd4;
      OP_OR:   alu_ctrl = 4'd5;
      default: alu_ctrl = 4'd2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (last_step) begin
      state_d = cu.stop ? S_HALT : S_T0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_T0;
        S_T0:    state_d = S_T1;
        S_T1:    state_d = S_T2;
        S_T2:    state_d = S_T3;
        S_T3:    state_d = op_halt ? S_HALT : S_T4;
        S_T4:    state_d = S_T5;
        S_T5:    state_d = S_T6;
        S_T6:    state_d = S_T7;
        S_T7:    state_d = S_T0;
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    cu.PCout = 1'b0;  cu.Zlowout = 1'b0; cu.MDRout = 1'b0; cu.MARin = 1'b0;
    cu.Zlowin = 1'b0; cu.PCin = 1'b0;    cu.MDRin = 1'b0;  cu.read = 1'b0;
    cu.write = 1'b0;  cu.IRin = 1'b0;    cu.Yin = 1'b0;    cu.IncPc = 1'b0;
    cu.Cout = 1'b0;   cu.BAout = 1'b0;   cu.Rin = 1'b0;    cu.Rout = 1'b0;
    cu.GRA = 1'b0;    cu.GRB = 1'b0;     cu.GRC = 1'b0;
    cu.mdr_read = 2'b00;
    cu.control  = 4'd0;
    cu.run      = (state_q != S_IDLE) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin
        cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPc = 1'b1; cu.Zlowin = 1'b1;
      end
      S_T1: begin
        cu.Zlowout = 1'b1; cu.PCin = 1'b1; cu.read = 1'b1; cu.MDRin = 1'b1;
        cu.mdr_read = 2'b01;
      end
      S_T2: begin
        cu.MDRout = 1'b1; cu.IRin = 1'b1;
      end
      S_T3: begin
        // memory forms use the base-address path, register forms read GRB
        if (op_mem || op_ldi) begin
          cu.GRB = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1;
        end else if (op_alu || op_addi) begin
          cu.GRB = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1;
        end
      end
      S_T4: begin
        if (op_mem || op_ldi || op_addi) begin
          cu.Cout = 1'b1; cu.control = 4'd2; cu.Zlowin = 1'b1;
        end else if (op_alu) begin
          cu.GRC = 1'b1; cu.Rout = 1'b1; cu.Zlowin = 1'b1; cu.control = alu_ctrl;
        end
      end
      S_T5: begin
        if (op_mem) begin
          cu.Zlowout = 1'b1; cu.MARin = 1'b1;
        end else if (op_short) begin
          cu.Zlowout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1;
        end
      end
      S_T6: begin
        if (op_ld) begin
          cu.read = 1'b1; cu.MDRin = 1'b1; cu.mdr_read = 2'b01;
        end else if (op_st) begin
          cu.GRA = 1'b1; cu.BAout = 1'b1; cu.MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (op_ld) begin
          cu.MDRout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1;
        end else if (op_st) begin
          cu.write = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule
